// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the writeback port arbiter.
//   wb_req_t     : one buffered write (destination index, data, FPU target flag)
//   REQ_*        : requester slot assignments on the arbiter ports
//   STARVE_W     : width of the per-requester starvation counters
//   sat_inc      : saturating increment for the starvation counters
package wb_arb_pkg;

  localparam int unsigned REQ_PIPE     = 0;
  localparam int unsigned REQ_FPU_LONG = 1;
  localparam int unsigned REQ_MMIO     = 2;
  localparam int unsigned STARVE_W     = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_fpu;
  } wb_req_t;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_prio_starve_picker.sv
// wb_prio_starve_picker: combinational fixed-priority picker with starvation
// promotion. Any full candidate whose counter has reached LIMIT is promoted;
// the lowest-index promoted candidate wins, otherwise the lowest-index full one.
//   full       in  N      candidate present
//   starve_cnt in  N x W  per-candidate consecutive-loss counters
//   grant      out N      one-hot grant (all zero when nothing is full)
//   forced     out 1      grant came from the promoted set
module wb_prio_starve_picker #(
  parameter int unsigned N     = 3,
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 8
) (
  input  logic [N-1:0]        full,
  input  logic [N-1:0][W-1:0] starve_cnt,
  output logic [N-1:0]        grant,
  output logic                forced
);

  logic [N-1:0] promo;
  logic [N-1:0] cand;
  logic         found;

  always_comb begin
    promo = '0;
    for (int unsigned i = 0; i < N; i++) begin
      promo[i] = full[i] && (starve_cnt[i] >= W'(LIMIT));
    end
    forced = |promo;
    cand   = forced ? promo : full;

    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port among NREQ writeback
// sources (0 = pipeline W stage, 1 = long-latency FPU, 2 = MMIO load return).
// Each source has a one-entry buffer; one buffered entry is granted per cycle
// and drives the registered write port on the following cycle.
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-source handshake (ready = !full || granted)
//   req_rd/data/is_fpu per-source write payload (5/32/1 bits each)
//   rd_w, result_w    write-port index and data (hold when idle)
//   reg_write_w       integer regfile enable (suppressed for x0)
//   fpu_reg_write_w   FPU regfile enable
//   grant_o           one-hot grant issued in the previous cycle
// Optional: WB_PORT_ARB_PERF_EN adds perf_conflict_cnt / perf_starve_cnt.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*5-1:0]  req_rd,
  input  logic [NREQ*32-1:0] req_data,
  input  logic [NREQ-1:0]    req_is_fpu,
  output logic [4:0]         rd_w,
  output logic [31:0]        result_w,
  output logic               reg_write_w,
  output logic               fpu_reg_write_w,
  output logic [NREQ-1:0]    grant_o
`ifdef WB_PORT_ARB_PERF_EN
  ,
  output logic [31:0]        perf_conflict_cnt,
  output logic [31:0]        perf_starve_cnt
`endif
);

  logic [NREQ-1:0]                full_q, full_d;
  wb_req_t [NREQ-1:0]             buf_q, buf_d;
  logic [NREQ-1:0][STARVE_W-1:0]  starve_q, starve_d;

  logic [4:0]      rd_w_q, rd_w_d;
  logic [31:0]     result_w_q, result_w_d;
  logic            reg_write_w_q, reg_write_w_d;
  logic            fpu_reg_write_w_q, fpu_reg_write_w_d;
  logic [NREQ-1:0] grant_o_q, grant_o_d;

  logic [NREQ-1:0] grant;
  logic            forced;
  wb_req_t         sel;

  wb_prio_starve_picker #(
    .N     (NREQ),
    .W     (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_picker (
    .full       (full_q),
    .starve_cnt (starve_q),
    .grant      (grant),
    .forced     (forced)
  );

  // A granted slot drains this cycle, so it can refill on the same edge.
  always_comb begin
    req_ready = ~full_q | grant;
  end

  always_comb begin
    full_d   = full_q;
    buf_d    = buf_q;
    starve_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      starve_d[i] = (full_q[i] && !grant[i]) ? sat_inc(starve_q[i]) : '0;
      if (grant[i]) begin
        full_d[i] = 1'b0;
      end
      if (req_valid[i] && req_ready[i]) begin
        full_d[i]       = 1'b1;
        buf_d[i].rd     = req_rd[i*5 +: 5];
        buf_d[i].data   = req_data[i*32 +: 32];
        buf_d[i].is_fpu = req_is_fpu[i];
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel = buf_q[i];
      end
    end

    rd_w_d            = rd_w_q;
    result_w_d        = result_w_q;
    reg_write_w_d     = 1'b0;
    fpu_reg_write_w_d = 1'b0;
    grant_o_d         = grant;
    if (|grant) begin
      rd_w_d            = sel.rd;
      result_w_d        = sel.data;
      reg_write_w_d     = !sel.is_fpu && (sel.rd != '0);
      fpu_reg_write_w_d = sel.is_fpu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q            <= '0;
      buf_q             <= '0;
      starve_q          <= '0;
      rd_w_q            <= '0;
      result_w_q        <= '0;
      reg_write_w_q     <= 1'b0;
      fpu_reg_write_w_q <= 1'b0;
      grant_o_q         <= '0;
    end else begin
      full_q            <= full_d;
      buf_q             <= buf_d;
      starve_q          <= starve_d;
      rd_w_q            <= rd_w_d;
      result_w_q        <= result_w_d;
      reg_write_w_q     <= reg_write_w_d;
      fpu_reg_write_w_q <= fpu_reg_write_w_d;
      grant_o_q         <= grant_o_d;
    end
  end

  assign rd_w            = rd_w_q;
  assign result_w        = result_w_q;
  assign reg_write_w     = reg_write_w_q;
  assign fpu_reg_write_w = fpu_reg_write_w_q;
  assign grant_o         = grant_o_q;

`ifdef WB_PORT_ARB_PERF_EN
  logic [31:0]  perf_conflict_q, perf_conflict_d;
  logic [31:0]  perf_starve_q, perf_starve_d;
  int unsigned  n_full;

  always_comb begin
    n_full = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      n_full = n_full + int'(full_q[i]);
    end
    perf_conflict_d = perf_conflict_q + ((n_full >= 2) ? 32'd1 : 32'd0);
    perf_starve_d   = perf_starve_q + ((forced && (|grant)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_starve_q   <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_starve_q   <= perf_starve_d;
    end
  end

  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_starve_cnt   = perf_starve_q;
`else
  logic perf_unused;
  assign perf_unused = forced;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [14:0] req_rd = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_is_fpu = '0;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        reg_write_w;
  logic        fpu_reg_write_w;
  logic [2:0]  grant_o;
`ifdef WB_PORT_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_starve_cnt;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .NREQ         (NREQ),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rd          (req_rd),
    .req_data        (req_data),
    .req_is_fpu      (req_is_fpu),
    .rd_w            (rd_w),
    .result_w        (result_w),
    .reg_write_w     (reg_write_w),
    .fpu_reg_write_w (fpu_reg_write_w),
    .grant_o         (grant_o)
`ifdef WB_PORT_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_starve_cnt   (perf_starve_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each source holds at most one pending write and a count
  // of consecutive cycles it waited while another source was served.
  bit          m_full [3];
  int          m_wait [3];
  logic [4:0]  m_rd   [3];
  logic [31:0] m_data [3];
  bit          m_fpu  [3];

  typedef struct {
    logic [2:0]  g;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        fwe;
  } exp_t;
  exp_t expq[$];

  function automatic int model_winner();
    int w = -1;
    for (int i = 0; i < 3; i++)
      if (w < 0 && m_full[i] && m_wait[i] >= int'(LIMIT)) w = i;
    for (int i = 0; i < 3; i++)
      if (w < 0 && m_full[i]) w = i;
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 0;
      m_wait[i] = 0;
    end
  endtask

  task automatic cycle(input logic [2:0] v, input logic [14:0] rds,
                       input logic [95:0] ds, input logic [2:0] fs);
    int w;
    logic [2:0] rdy;
    exp_t e;
    @(negedge clk);
    w = model_winner();
    for (int i = 0; i < 3; i++) rdy[i] = !m_full[i] || (w == i);
    chk("req_ready", 64'(req_ready), 64'(rdy));
    req_valid  = v;
    req_rd     = rds;
    req_data   = ds;
    req_is_fpu = fs;
    if (w >= 0) begin
      e.g    = 3'b001 << w;
      e.rd   = m_rd[w];
      e.data = m_data[w];
      e.we   = !m_fpu[w] && (m_rd[w] != 5'd0);
      e.fwe  = m_fpu[w];
      expq.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      if (w == i) begin
        m_full[i] = 0;
        m_wait[i] = 0;
      end else if (m_full[i]) begin
        m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
      end else begin
        m_wait[i] = 0;
      end
      if (v[i] && rdy[i]) begin
        m_full[i] = 1;
        m_rd[i]   = rds[i*5 +: 5];
        m_data[i] = ds[i*32 +: 32];
        m_fpu[i]  = fs[i];
      end
    end
  endtask

  task automatic idle();
    cycle(3'b000, '0, '0, 3'b000);
  endtask

  task automatic one(input int unsigned idx, input logic [4:0] rd,
                     input logic [31:0] d, input logic f);
    logic [2:0]  v  = '0;
    logic [14:0] rs = '0;
    logic [95:0] ds = '0;
    logic [2:0]  fs = '0;
    v[idx]          = 1'b1;
    rs[idx*5 +: 5]  = rd;
    ds[idx*32 +: 32] = d;
    fs[idx]         = f;
    cycle(v, rs, ds, fs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'(3'b111));
    chk("rst_grant_o", 64'(grant_o), 64'(0));
    chk("rst_reg_write", 64'(reg_write_w), 64'(0));
    chk("rst_fpu_write", 64'(fpu_reg_write_w), 64'(0));
    chk("rst_rd_w", 64'(rd_w), 64'(0));
    chk("rst_result_w", 64'(result_w), 64'(0));
  endtask

  // Monitor: pops one expected write whenever the DUT reports a grant.
  initial begin
    logic [4:0]  last_rd;
    logic [31:0] last_res;
    exp_t e;
    last_rd  = '0;
    last_res = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_rd  = '0;
        last_res = '0;
      end else if (grant_o != 3'b000) begin
        if (expq.size() == 0) begin
          chk("unexpected_grant", 64'(grant_o), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("grant_o", 64'(grant_o), 64'(e.g));
          chk("rd_w", 64'(rd_w), 64'(e.rd));
          chk("result_w", 64'(result_w), 64'(e.data));
          chk("reg_write_w", 64'(reg_write_w), 64'(e.we));
          chk("fpu_reg_write_w", 64'(fpu_reg_write_w), 64'(e.fwe));
          last_rd  = e.rd;
          last_res = e.data;
        end
      end else begin
        chk("idle_enables", 64'({reg_write_w, fpu_reg_write_w}), 64'(0));
        chk("hold_rd_w", 64'(rd_w), 64'(last_rd));
        chk("hold_result_w", 64'(result_w), 64'(last_res));
      end
    end
  end

  initial begin
    logic [2:0]  v;
    logic [14:0] rs;
    logic [95:0] ds;
    logic [2:0]  fs;

    model_clear();
    do_reset();

    // Single write on an idle port appears exactly two edges after issue.
    one(1, 5'd5, 32'hDEADBEEF, 1'b0);
    idle();
    @(posedge clk);
    #2;
    chk("lat_reg_write", 64'(reg_write_w), 64'(1));
    chk("lat_rd_w", 64'(rd_w), 64'(5));
    chk("lat_result_w", 64'(result_w), 64'(32'hDEADBEEF));
    chk("lat_fpu_write", 64'(fpu_reg_write_w), 64'(0));
    idle();

    // Requesters 0 and 2 together: 0 first, 2 next cycle.
    cycle(3'b101, {5'd9, 5'd0, 5'd7}, {32'h2222, 32'h0, 32'h1111}, 3'b000);
    idle();
    idle();
    idle();

    // Requester 0 streams every cycle while requester 1 waits for promotion.
    cycle(3'b011, {5'd0, 5'd3, 5'd4}, {32'h0, 32'hAAAA, 32'h1000}, 3'b000);
    for (int unsigned k = 0; k < 12; k++)
      one(0, 5'(k + 10), 32'h2000 + k, 1'b0);
    idle();
    idle();
    idle();

    // Integer x0 suppressed, FPU f0 written.
    one(2, 5'd0, 32'h1234, 1'b0);
    idle();
    one(1, 5'd0, 32'h3F800000, 1'b1);
    idle();
    idle();

    // Reset with two buffers full discards them.
    cycle(3'b011, {5'd0, 5'd8, 5'd6}, {32'h0, 32'hBBBB, 32'hCCCC}, 3'b010);
    do_reset();
    idle();
    idle();

    // Randomized traffic with occasional resets.
    for (int unsigned k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        for (int unsigned i = 0; i < 3; i++) begin
          v[i]            = ($urandom_range(0, 3) != 0);
          rs[i*5 +: 5]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          ds[i*32 +: 32]  = $urandom;
          fs[i]           = 1'($urandom_range(0, 1));
        end
        cycle(v, rs, ds, fs);
      end
    end
    for (int unsigned k = 0; k < 6; k++) idle();
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(expq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
